// File: rtl/half_subtractor_pkg.sv
// rtl/half_subtractor_pkg.sv - shared width default and per-bit result type for the half subtractor
package half_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 1;

    typedef struct packed {
        logic diff;
        logic borrow;
    } hs_bit_t;

    function automatic hs_bit_t hs_eval(input logic a, input logic b);
        hs_bit_t r;
        r.diff   = a ^ b;
        r.borrow = ~a & b;
        return r;
    endfunction

endpackage

// File: rtl/half_sub_bit.sv
// rtl/half_sub_bit.sv - single-lane combinational half subtractor cell
module half_sub_bit
    import half_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);

    hs_bit_t result;

    assign result = hs_eval(a, b);
    assign diff   = result.diff;
    assign borrow = result.borrow;

endmodule

// File: rtl/half_subtractor.sv
// rtl/half_subtractor.sv - bitwise half subtractor with combinational and one-cycle registered outputs
module half_subtractor
    import half_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] borrow,
    output logic [WIDTH-1:0] diff_q,
    output logic [WIDTH-1:0] borrow_q,
    output logic             out_valid
);

    // Lanes are fully independent: no borrow ripples between cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_sub_bit u_bit (
            .a      (a[i]),
            .b      (b[i]),
            .diff   (diff[i]),
            .borrow (borrow[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q    <= '0;
            borrow_q  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                diff_q   <= diff;
                borrow_q <= borrow;
            end
        end
    end

endmodule

// File: tb/tb_half_subtractor.sv
// tb/tb_half_subtractor.sv - self-checking bench for half_subtractor at WIDTH=1 and WIDTH=4
module tb_half_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, iv1 = 1'b0;
    logic       diff1, borrow1, dq1, bq1, ov1;
    logic [3:0] a4 = '0, b4 = '0;
    logic       iv4 = 1'b0;
    logic [3:0] diff4, borrow4, dq4, bq4;
    logic       ov4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    half_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1),
        .diff(diff1), .borrow(borrow1), .diff_q(dq1), .borrow_q(bq1), .out_valid(ov1)
    );

    half_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(iv4),
        .diff(diff4), .borrow(borrow4), .diff_q(dq4), .borrow_q(bq4), .out_valid(ov4)
    );

    // Per lane: integer a-b in {-1,0,1}; nonzero gives diff, negative gives borrow.
    function automatic logic [7:0] ref_sub(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] d, br;
        for (int i = 0; i < 4; i++) begin
            int s;
            s = int'(x[i]) - int'(y[i]);
            d[i]  = (s != 0);
            br[i] = (s < 0);
        end
        return {br, d};
    endfunction

    task automatic test_reset();
        #1;
        checks++; if ({dq1, bq1, ov1} !== 3'b000) begin errors++; $display("FAIL reset_w1 got=%b exp=000", {dq1, bq1, ov1}); end
        checks++; if ({dq4, bq4, ov4} !== 9'b0) begin errors++; $display("FAIL reset_w4 got=%b exp=0", {dq4, bq4, ov4}); end
    endtask

    task automatic test_comb_sweep();
        logic [7:0] e;
        for (int v = 0; v < 4; v++) begin
            a1 = v[1]; b1 = v[0];
            #10;
            e = ref_sub({3'b0, a1}, {3'b0, b1});
            checks++; if ({diff1, borrow1} !== {e[0], e[4]})
                begin errors++; $display("FAIL comb_sweep ab=%b%b got=%b%b exp=%b%b", a1, b1, diff1, borrow1, e[0], e[4]); end
        end
        // Reset is still held: registered outputs must stay cleared.
        checks++; if ({dq1, bq1, ov1} !== 3'b000) begin errors++; $display("FAIL reset_hold got=%b exp=000", {dq1, bq1, ov1}); end
    endtask

    task automatic test_capture();
        @(negedge clk); rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b1; iv1 = 1'b1;
        #1;
        checks++; if ({diff1, borrow1} !== 2'b11) begin errors++; $display("FAIL capture_comb got=%b%b exp=11", diff1, borrow1); end
        @(posedge clk); #1;
        checks++; if ({dq1, bq1, ov1} !== 3'b111) begin errors++; $display("FAIL capture_q got=%b exp=111", {dq1, bq1, ov1}); end
        @(negedge clk); iv1 = 1'b0;
    endtask

    task automatic test_lanes();
        logic [7:0] e;
        a4 = 4'b1010; b4 = 4'b0110;
        #1;
        e = ref_sub(a4, b4);
        checks++; if (diff4 !== 4'b1100 || diff4 !== e[3:0]) begin errors++; $display("FAIL lanes_diff got=%b exp=1100", diff4); end
        checks++; if (borrow4 !== 4'b0100 || borrow4 !== e[7:4]) begin errors++; $display("FAIL lanes_borrow got=%b exp=0100", borrow4); end
    endtask

    task automatic test_hold();
        @(negedge clk); a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1;
        @(posedge clk); #1;
        checks++; if ({dq1, bq1, ov1} !== 3'b101) begin errors++; $display("FAIL hold_capture got=%b exp=101", {dq1, bq1, ov1}); end
        @(negedge clk); a1 = 1'b1; b1 = 1'b1; iv1 = 1'b0;
        @(posedge clk); #1;
        checks++; if ({dq1, bq1, ov1} !== 3'b100) begin errors++; $display("FAIL hold_retain got=%b exp=100", {dq1, bq1, ov1}); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); a1 = 1'b0; b1 = 1'b1; iv1 = 1'b1;
        @(posedge clk); #1;
        checks++; if ({dq1, bq1, ov1} !== 3'b111) begin errors++; $display("FAIL async_pre got=%b exp=111", {dq1, bq1, ov1}); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({dq1, bq1, ov1} !== 3'b000) begin errors++; $display("FAIL async_clear got=%b exp=000", {dq1, bq1, ov1}); end
        a1 = 1'b1; b1 = 1'b0;
        #1;
        checks++; if ({diff1, borrow1} !== 2'b10) begin errors++; $display("FAIL async_comb got=%b%b exp=10", diff1, borrow1); end
        // Edge with in_valid high while reset is held: reset wins.
        @(posedge clk); #1;
        checks++; if ({dq1, bq1, ov1} !== 3'b000) begin errors++; $display("FAIL reset_wins got=%b exp=000", {dq1, bq1, ov1}); end
    endtask

    task automatic test_reset_release();
        @(negedge clk); rst_n = 1'b1; a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        @(posedge clk); #1;
        checks++; if ({dq1, bq1, ov1} !== 3'b001) begin errors++; $display("FAIL release_first got=%b exp=001", {dq1, bq1, ov1}); end
    endtask

    task automatic test_random();
        logic [7:0] e1, e4;
        logic [1:0] q1;
        logic [7:0] q4;
        logic       o1, o4;
        q1 = '0; q4 = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            a1 = 1'($urandom); b1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom);
            iv1 = (n == 0) ? 1'b1 : 1'($urandom);
            iv4 = (n == 0) ? 1'b1 : 1'($urandom);
            #1;
            e1 = ref_sub({3'b0, a1}, {3'b0, b1});
            e4 = ref_sub(a4, b4);
            checks++; if ({diff1, borrow1} !== {e1[0], e1[4]}) begin errors++; $display("FAIL rnd_comb1 n=%0d got=%b%b exp=%b%b", n, diff1, borrow1, e1[0], e1[4]); end
            checks++; if ({borrow4, diff4} !== e4) begin errors++; $display("FAIL rnd_comb4 n=%0d got=%b exp=%b", n, {borrow4, diff4}, e4); end
            if (iv1) q1 = {e1[0], e1[4]};
            if (iv4) q4 = e4;
            o1 = iv1; o4 = iv4;
            @(posedge clk); #1;
            checks++; if ({dq1, bq1, ov1} !== {q1, o1}) begin errors++; $display("FAIL rnd_reg1 n=%0d got=%b exp=%b", n, {dq1, bq1, ov1}, {q1, o1}); end
            checks++; if ({bq4, dq4, ov4} !== {q4, o4}) begin errors++; $display("FAIL rnd_reg4 n=%0d got=%b exp=%b", n, {bq4, dq4, ov4}, {q4, o4}); end
        end
    endtask

    initial begin
        test_reset();
        test_comb_sweep();
        test_capture();
        test_lanes();
        test_hold();
        test_async_reset();
        test_reset_release();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
